// File: rtl/gate_bist_checker.sv
// Exhaustive BIST checker for a two-input gate: walks {a,b} through all four patterns,
// compares two gate implementations against a truth table and reports per-pattern failures.
module gate_bist_checker #(
    parameter int unsigned HOLD_CYCLES = 20,
    parameter logic [3:0]  TRUTH       = 4'b1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       y,
    input  logic       t,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {StIdle, StApply, StDone} state_e;

    localparam logic [7:0] LastCnt = 8'(HOLD_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] ab_q, ab_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [2:0] err_q, err_d;
    logic [3:0] fvec_q, fvec_d;

    logic       expect_bit;
    logic       mismatch;
    logic [2:0] err_inc;
    logic [3:0] fvec_upd;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ab_d    = ab_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fvec_d  = fvec_q;

        // Either implementation disagreeing with the table fails the pattern once.
        expect_bit = TRUTH[ab_q];
        mismatch   = (y != expect_bit) || (t != expect_bit);
        err_inc    = err_q + {2'b00, mismatch};
        fvec_upd   = fvec_q | ({3'b000, mismatch} << ab_q);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StApply;
                    busy_d  = 1'b1;
                    ab_d    = 2'b00;
                    cnt_d   = '0;
                    err_d   = '0;
                    fvec_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            StApply: begin
                if (cnt_q == LastCnt) begin
                    err_d  = err_inc;
                    fvec_d = fvec_upd;
                    cnt_d  = '0;
                    if (ab_q == 2'b11) begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_inc == 3'd0);
                        ab_d    = 2'b00;
                    end else begin
                        ab_d = ab_q + 2'b01;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ab_q    <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fvec_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ab_q    <= ab_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fvec_q  <= fvec_d;
        end
    end

    assign a         = ab_q[1];
    assign b         = ab_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fvec_q;

endmodule

// File: tb/tb_gate_bist_checker.sv
// Bench for gate_bist_checker: an AND-table instance and an OR-table instance share start
// and reset; a run-level model predicts every output each cycle.
module tb_gate_bist_checker;

    localparam int unsigned HOLD = 4;
    localparam logic [3:0]  TRUTH0 = 4'b1000;
    localparam logic [3:0]  TRUTH1 = 4'b1110;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       d_a [2];
    logic       d_b [2];
    logic       d_y [2];
    logic       d_t [2];
    logic       d_busy [2];
    logic       d_done [2];
    logic       d_pass [2];
    logic [2:0] d_err [2];
    logic [3:0] d_fvec [2];

    // Gate behaviour tables: bit i is the gate output for {a,b}=i.
    logic [3:0] ytab [2];
    logic [3:0] ttab [2];

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign d_y[0] = ytab[0][{d_a[0], d_b[0]}];
    assign d_t[0] = ttab[0][{d_a[0], d_b[0]}];
    assign d_y[1] = ytab[1][{d_a[1], d_b[1]}];
    assign d_t[1] = ttab[1][{d_a[1], d_b[1]}];

    gate_bist_checker #(.HOLD_CYCLES(HOLD), .TRUTH(TRUTH0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(d_a[0]), .b(d_b[0]), .y(d_y[0]),
        .t(d_t[0]), .busy(d_busy[0]), .done(d_done[0]), .pass(d_pass[0]),
        .err_count(d_err[0]), .fail_vec(d_fvec[0])
    );

    gate_bist_checker #(.HOLD_CYCLES(HOLD), .TRUTH(TRUTH1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(d_a[1]), .b(d_b[1]), .y(d_y[1]),
        .t(d_t[1]), .busy(d_busy[1]), .done(d_done[1]), .pass(d_pass[1]),
        .err_count(d_err[1]), .fail_vec(d_fvec[1])
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic logic [3:0] fail_mask(input int i);
        logic [3:0] tr;
        tr = (i == 0) ? TRUTH0 : TRUTH1;
        return (ytab[i] ^ tr) | (ttab[i] ^ tr);
    endfunction

    // Run-level model: cycles since the accepted start edge, plus the result of the last run.
    logic       m_run [2];
    logic       m_done [2];
    logic       m_pass [2];
    int         m_k [2];
    logic [3:0] m_mask [2];
    logic [3:0] m_fvec [2];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_run[i]  <= 1'b0;
                m_done[i] <= 1'b0;
                m_pass[i] <= 1'b0;
                m_k[i]    <= 0;
                m_mask[i] <= '0;
                m_fvec[i] <= '0;
            end else begin
                m_done[i] <= 1'b0;
                if (m_run[i]) begin
                    if (m_k[i] + 1 == 4 * HOLD) begin
                        m_run[i]  <= 1'b0;
                        m_done[i] <= 1'b1;
                        m_fvec[i] <= m_mask[i];
                        m_pass[i] <= (m_mask[i] == 4'b0000);
                    end else begin
                        m_k[i] <= m_k[i] + 1;
                    end
                end else if (!m_done[i] && start) begin
                    m_run[i]  <= 1'b1;
                    m_k[i]    <= 0;
                    m_mask[i] <= fail_mask(i);
                    m_fvec[i] <= '0;
                    m_pass[i] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int         pat;
            logic [3:0] ef;
            pat = m_run[i] ? m_k[i] / HOLD : 0;
            ef  = m_run[i] ? (m_mask[i] & 4'((1 << pat) - 1)) : m_fvec[i];
            check($sformatf("ab%0d", i), {d_a[i], d_b[i]}, pat);
            check($sformatf("busy%0d", i), d_busy[i], m_run[i]);
            check($sformatf("done%0d", i), d_done[i], m_done[i]);
            check($sformatf("pass%0d", i), d_pass[i], m_pass[i]);
            check($sformatf("err%0d", i), d_err[i], $countones(ef));
            check($sformatf("fvec%0d", i), d_fvec[i], ef);
        end
    end

    // Pulses start, then waits (bounded) for done on dut0; records {a,b} mid-hold of each pattern.
    task automatic run_until_done(output int lat, output logic [7:0] seq);
        int n;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n   = 0;
        seq = '0;
        while (d_done[0] !== 1'b1 && n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (n % HOLD == 1) seq = {seq[5:0], d_a[0], d_b[0]};
        end
        lat = n;
    endtask

    initial begin
        int         lat;
        int         dones;
        logic [7:0] seq;

        ytab[0] = TRUTH0; ttab[0] = TRUTH0;
        ytab[1] = TRUTH1; ttab[1] = TRUTH1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", d_busy[0], 0);
        check("reset_fvec", d_fvec[0], 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Correct AND and OR gates.
        run_until_done(lat, seq);
        check("and_latency", lat, 16);
        check("and_seq", seq, 8'b00_01_10_11);
        check("and_pass", d_pass[0], 1);
        check("and_err", d_err[0], 0);
        check("or_pass", d_pass[1], 1);
        repeat (3) @(posedge clk);
        #1;

        // y stuck at 1 on the AND instance; AND gates under the OR table.
        ytab[0] = 4'b1111;
        ytab[1] = 4'b1000; ttab[1] = 4'b1000;
        run_until_done(lat, seq);
        check("stuck_err", d_err[0], 3);
        check("stuck_fvec", d_fvec[0], 4'b0111);
        check("stuck_pass", d_pass[0], 0);
        check("or_and_err", d_err[1], 2);
        check("or_and_fvec", d_fvec[1], 4'b0110);
        repeat (2) @(posedge clk);
        #1;
        check("hold_fvec", d_fvec[0], 4'b0111);

        // NAND table on t.
        ytab[0] = TRUTH0; ttab[0] = 4'b0111;
        run_until_done(lat, seq);
        check("nand_err", d_err[0], 4);
        check("nand_fvec", d_fvec[0], 4'b1111);
        check("nand_pass", d_pass[0], 0);
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-run aborts without a done pulse.
        ttab[0] = TRUTH0;
        ytab[1] = TRUTH1; ttab[1] = TRUTH1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_busy", d_busy[0], 1);
        check("pre_reset_ab", {d_a[0], d_b[0]}, 2'b01);
        rst_n = 1'b0;
        #1;
        check("async_busy", d_busy[0], 0);
        check("async_ab", {d_a[0], d_b[0]}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (d_done[0]) dones++;
        end
        check("abort_no_done", dones, 0);
        run_until_done(lat, seq);
        check("after_reset_lat", lat, 16);
        check("after_reset_pass", d_pass[0], 1);
        repeat (2) @(posedge clk);
        #1;

        // start during APPLY and during DONE is ignored.
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dones = 0;
        for (int n = 1; n <= 24; n++) begin
            @(posedge clk);
            #1;
            if (d_done[0]) dones++;
            start = (n == 5) || (d_done[0] === 1'b1);
        end
        start = 1'b0;
        check("single_done", dones, 1);
        check("idle_after_ignored", d_busy[0], 0);
        run_until_done(lat, seq);
        check("restart_seq", seq, 8'b00_01_10_11);
        check("restart_lat", lat, 16);
        repeat (3) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
